// File: rtl/binary_to_bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter: one bit per clock, IN_WIDTH clocks per result.
// Optional two's-complement input handling is built when macro BCD_SIGNED_EN is defined.
module binary_to_bcd_seq_converter #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
`ifdef BCD_SIGNED_EN
  ,
  output logic                  sign
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(IN_WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  accept_s;
  logic                  finish_s;
  logic [IN_WIDTH-1:0]   shreg_r;
  logic [IN_WIDTH-1:0]   shreg_nxt_s;
  logic [BW-1:0]         acc_r;
  logic [BW-1:0]         acc_adj_s;
  logic [BW-1:0]         acc_nxt_s;
  logic                  shout_s;
  logic                  ovf_r;
  logic [CW-1:0]         cnt_r;
  logic [IN_WIDTH-1:0]   load_val_s;
`ifdef BCD_SIGNED_EN
  logic                  load_sign_s;
  logic                  sign_pend_r;
`endif

  // Digit correction: any digit of 5 or more gets +3 so the following shift carries decimally.
  function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = a[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Value loaded into the shift register on start (magnitude when signed input is enabled).
  always_comb begin
    load_val_s = bin_in;
`ifdef BCD_SIGNED_EN
    load_sign_s = bin_in[IN_WIDTH-1];
    if (bin_in[IN_WIDTH-1]) begin
      // The most negative value negates to itself, which read unsigned is its full magnitude.
      load_val_s = ~bin_in + {{(IN_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      load_val_s = bin_in;
    end
`endif
  end

  // One double-dabble step: correct digits, then shift {accumulator, shift register} left.
  always_comb begin
    acc_adj_s   = add3_digits(acc_r);
    acc_nxt_s   = {acc_adj_s[BW-2:0], shreg_r[IN_WIDTH-1]};
    shreg_nxt_s = {shreg_r[IN_WIDTH-2:0], 1'b0};
    shout_s     = acc_adj_s[BW-1];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus load/finish strobes for the datapath.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST_CNT) begin
          finish_s    = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs; results publish only on the finishing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_r  <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      ovf_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
`ifdef BCD_SIGNED_EN
      sign_pend_r <= 1'b0;
      sign        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept_s) begin
        shreg_r <= load_val_s;
        acc_r   <= '0;
        cnt_r   <= '0;
        ovf_r   <= 1'b0;
        busy    <= 1'b1;
`ifdef BCD_SIGNED_EN
        sign_pend_r <= load_sign_s;
`endif
      end else if (state_r == SHIFT) begin
        acc_r   <= acc_nxt_s;
        shreg_r <= shreg_nxt_s;
        cnt_r   <= cnt_r + CW'(1);
        ovf_r   <= ovf_r | shout_s;
        if (finish_s) begin
          bcd_out  <= acc_nxt_s;
          overflow <= ovf_r | shout_s;
          done     <= 1'b1;
          busy     <= 1'b0;
`ifdef BCD_SIGNED_EN
          sign     <= sign_pend_r;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_seq_converter.sv
// Scoreboard bench: two converters (3 and 2 digits, 8-bit input) share stimulus; a monitor
// pops expected results computed with decimal arithmetic whenever done is seen.
module tb_binary_to_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
`ifdef BCD_SIGNED_EN
  logic        sign3, sign2;
`endif

  binary_to_bcd_seq_converter #(.IN_WIDTH(8), .DIGITS(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
`ifdef BCD_SIGNED_EN
    , .sign(sign3)
`endif
  );

  binary_to_bcd_seq_converter #(.IN_WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
`ifdef BCD_SIGNED_EN
    , .sign(sign2)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] bcd3;
    logic        ovf3;
    logic [7:0]  bcd2;
    logic        ovf2;
    logic        sgn;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   pend_done = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic exp_t model(input logic [7:0] v, input int due);
    exp_t e;
    int mag, m;
    e.sgn = 1'b0;
    mag = int'(v);
`ifdef BCD_SIGNED_EN
    if (v[7]) begin
      e.sgn = 1'b1;
      mag = 256 - int'(v);
    end
`endif
    e.ovf3 = (mag >= 1000);
    e.ovf2 = (mag >= 100);
    e.bcd3 = '0;
    e.bcd2 = '0;
    m = mag % 1000;
    for (int i = 0; i < 3; i++) begin
      e.bcd3[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    m = mag % 100;
    for (int i = 0; i < 2; i++) begin
      e.bcd2[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    e.due = due;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called just after a negedge: present start for one cycle; the model decides acceptance.
  task automatic issue(input logic [7:0] v);
    int n;
    n = cyc;
    start  = 1'b1;
    bin_in = v;
    if (n >= pend_done) begin
      pend_done = n + 9;
      sb.push_back(model(v, n + 9));
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (cyc < pend_done && g < 40) begin
      @(negedge clk);
      g++;
    end
  endtask

  // Monitor: busy profile every cycle, result comparison on every done.
  always @(negedge clk) begin
    if (!reset) begin
      chk("busy_d3", 32'(busy3), 32'((cyc >= pend_done - 8) && (cyc < pend_done)));
      chk("busy_d2", 32'(busy2), 32'((cyc >= pend_done - 8) && (cyc < pend_done)));
      if (sb.size() != 0 && cyc > sb[0].due) begin
        chk("missing_done", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      if (done3 || done2) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(mon_e.due));
          chk("done_both", 32'({done3, done2}), 32'h3);
          chk("bcd_d3", 32'(bcd3), 32'(mon_e.bcd3));
          chk("ovf_d3", 32'(ovf3), 32'(mon_e.ovf3));
          chk("bcd_d2", 32'(bcd2), 32'(mon_e.bcd2));
          chk("ovf_d2", 32'(ovf2), 32'(mon_e.ovf2));
`ifdef BCD_SIGNED_EN
          chk("sign_d3", 32'(sign3), 32'(mon_e.sgn));
          chk("sign_d2", 32'(sign2), 32'(mon_e.sgn));
`endif
        end
      end
    end
  end

  initial begin
    int g;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy3), 32'h0);
    chk("reset_done", 32'(done3), 32'h0);
    chk("reset_bcd", 32'(bcd3), 32'h0);
    chk("reset_ovf", 32'(ovf3), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed: full scale, zero, overflow on the 2-digit unit.
    issue(8'd255); wait_idle();
    issue(8'd0);   wait_idle();
    issue(8'd200); wait_idle();
    issue(8'd99);  wait_idle();

    // Start while busy is ignored; start in the done cycle is taken back-to-back.
    issue(8'd123);
    @(negedge clk); @(negedge clk);
    issue(8'd45);
    wait_idle();
    issue(8'd77);
    wait_idle();

    // Sign-bit patterns (magnitudes when signed input is enabled).
    issue(8'h80); wait_idle();
    issue(8'hFF); wait_idle();
    issue(8'h7F); wait_idle();

    // Asynchronous reset in the middle of a conversion.
    issue(8'd200);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy3), 32'h0);
    chk("abort_done", 32'(done3), 32'h0);
    chk("abort_bcd3", 32'(bcd3), 32'h0);
    chk("abort_bcd2", 32'(bcd2), 32'h0);
    chk("abort_ovf2", 32'(ovf2), 32'h0);
    sb.delete();
    pend_done = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(8'd17); wait_idle();

    // Randomized traffic with random gaps; starts landing while busy must be ignored.
    for (int k = 0; k < 200; k++) begin
      issue(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end

    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 32'(sb.size()), 32'h0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_seq_converter.md
BINARY_TO_BCD_SEQ_CONVERTER -- requirements
Module: binary_to_bcd_seq_converter

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 8, giving the binary input width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter DIGITS, default 3, giving the number of BCD output digits (legal range 1..10).
REQ-003 The block SHALL have input port clk, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have input port reset, 1 bit, the asynchronous, active-high reset.
REQ-005 The block SHALL have input port start, 1 bit, a conversion request sampled on the clk rising edge.
REQ-006 The block SHALL have input port bin_in, IN_WIDTH bits, the binary value, sampled only on the edge that accepts start.
REQ-007 The block SHALL have output port busy, 1 bit, high while a conversion is in progress.
REQ-008 The block SHALL have output port done, 1 bit, a one-cycle completion pulse.
REQ-009 The block SHALL have output port bcd_out, 4*DIGITS bits, the registered result with digit 0 (units) in bits [3:0].
REQ-010 The block SHALL have output port overflow, 1 bit, high when the last result exceeded the DIGITS capacity.
REQ-011 The block SHALL have output port sign, 1 bit, the sign of the last result, present only when BCD_SIGNED_EN is defined.

Function
REQ-012 The block SHALL implement two states: IDLE and SHIFT.
REQ-013 In IDLE, start=1 SHALL load bin_in into a shift register, clear the BCD accumulator and bit counter, and enter SHIFT; busy SHALL be high from the next cycle.
REQ-014 In SHIFT, each edge SHALL add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by one bit, then increment the counter.
REQ-015 After exactly IN_WIDTH SHIFT edges, the block SHALL write the accumulator to bcd_out, pulse done high for one cycle, drop busy, and return to IDLE (done first visible IN_WIDTH edges after the start-accepting edge).
REQ-016 bcd_out, overflow and sign SHALL hold their values until the next done; they SHALL NOT change during SHIFT.
REQ-017 start SHALL be ignored while busy=1; a conversion in progress SHALL NOT be restarted or corrupted by it.
REQ-018 start=1 in the cycle in which done=1 SHALL be accepted (busy=0 in that cycle), giving back-to-back conversions with no idle cycle.
REQ-019 Any 1 shifted out of the top digit during a conversion SHALL set overflow for that result; bcd_out SHALL then equal the input modulo 10^DIGITS.
REQ-020 The counter SHALL be sized ceil(log2(IN_WIDTH+1)) bits; no intermediate arithmetic SHALL wrap except the top-digit shift-out described in REQ-019.

Reset
REQ-021 Asserting reset SHALL immediately, without a clock edge, force state IDLE, busy=0, done=0, bcd_out=0, overflow=0, sign=0, and clear the counter and internal registers.
REQ-022 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; the first start after reset deassertion SHALL be accepted normally.

Configuration
REQ-023 When macro BCD_SIGNED_EN is defined, bin_in SHALL be treated as two's complement: on load, sign SHALL capture bin_in[IN_WIDTH-1] and the magnitude (negated if negative) SHALL be converted; -2^(IN_WIDTH-1) SHALL convert to its full magnitude.
REQ-024 When BCD_SIGNED_EN is not defined, bin_in SHALL be unsigned, port sign SHALL be absent, and no negation logic SHALL be built.

Verification
REQ-025 IN_WIDTH=8, DIGITS=3, bin_in=255, start pulse -> done 8 edges later, bcd_out=0x255, overflow=0; bin_in=0 -> bcd_out=0x000.
REQ-026 IN_WIDTH=16, DIGITS=5, bin_in=65535 -> done 16 edges later, bcd_out=0x65535, overflow=0.
REQ-027 IN_WIDTH=8, DIGITS=2, bin_in=200 -> bcd_out=0x00, overflow=1; then bin_in=99 -> bcd_out=0x99, overflow=0.
REQ-028 Start 123, pulse start with 45 at edge 3 while busy, then start 77 in the done cycle -> results 0x123 then 0x077, with no result for 45 and exactly two done pulses.
REQ-029 Reset asserted at edge 4 of a conversion of 200 -> outputs 0 immediately, no done; next start with 17 -> bcd_out=0x017.
REQ-030 With BCD_SIGNED_EN, IN_WIDTH=8: bin_in=0x80 -> sign=1, bcd_out=0x128; bin_in=0xFF -> sign=1, bcd_out=0x001; bin_in=0x7F -> sign=0, bcd_out=0x127.
